barrel_shifter_pipe: RTL

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/barrel_shifter_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/barrel_shifter_pipe.sv
// Two-stage pipelined barrel shifter with valid/ready handshaking.
// Stage 1 applies the coarse part of the shift (upper shift bits). Stage 2
// applies the fine part (lower shift bits) and drives the result. The
// operations compose exactly: logical and rotate shifts add up, and an
// arithmetic right shift keeps the sign bit in place. The two-step result
// therefore matches a single shift by the full amount.
// WIDTH must be a power of two between 4 and 64. SHW must keep its default.

module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shift,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Fine (stage 2) and coarse (stage 1) shift-amount field widths
  localparam int FW = SHW / 2;
  localparam int CW = SHW - FW;

  // Effective operation after folding in direction and reserved mode:
  // arithmetic left is plain logical left, and mode 11 is logical
  typedef enum logic [1:0] {
    OP_LOGICAL = 2'd0,
    OP_ARITH   = 2'd1,
    OP_ROTATE  = 2'd2
  } op_e;

  // Shift x by amt in the given direction.
  // Rotation ORs in the bits pushed off the far end. When amt is zero,
  // the wrap-around shift is by WIDTH and contributes nothing.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] x,
    input logic [SHW:0]     amt,
    input logic             right,
    input op_e              op
  );
    logic [WIDTH-1:0] fwd;
    logic [WIDTH-1:0] back;
    logic [SHW:0]     rev;
    rev = (SHW+1)'(WIDTH) - amt;
    if (right) begin
      fwd  = x >> amt;
      back = x << rev;
    end else begin
      fwd  = x << amt;
      back = x >> rev;
    end
    case (op)
      OP_ROTATE: shift_by = fwd | back;
      OP_ARITH:  shift_by = WIDTH'($signed(x) >>> amt);
      default:   shift_by = fwd;
    endcase
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [FW-1:0]    s1_fine;
  logic             s1_dir;
  op_e              s1_op;

  logic             s2_load;
  op_e              in_op;
  logic [SHW:0]     coarse_amt;
  logic [SHW:0]     fine_amt;
  logic [WIDTH-1:0] coarse_val;
  logic [WIDTH-1:0] fine_val;

  // Stage 2 can take a new beat when it is empty or its beat is leaving.
  // Stage 1 can take a new beat when it is empty or it is moving forward.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Decode the operation and compute the coarse shift on the incoming beat
  always_comb begin
    in_op = OP_LOGICAL;
    if (mode == 2'b10) begin
      in_op = OP_ROTATE;
    end else if (mode == 2'b01 && dir) begin
      in_op = OP_ARITH;
    end
    coarse_amt = {1'b0, shift[SHW-1:FW], {FW{1'b0}}};
    coarse_val = shift_by(data, coarse_amt, dir, in_op);
  end

  // Finish the shift in stage 2 using the fine amount carried with the beat
  always_comb begin
    fine_amt = {{(CW+1){1'b0}}, s1_fine};
    fine_val = shift_by(s1_data, fine_amt, s1_dir, s1_op);
  end

  // Stage 1 register: capture the partially shifted beat when there is room
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_fine  <= '0;
      s1_dir   <= 1'b0;
      s1_op    <= OP_LOGICAL;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= coarse_val;
        s1_fine <= shift[FW-1:0];
        s1_dir  <= dir;
        s1_op   <= in_op;
      end
    end
  end

  // Stage 2 register: hold the output while stalled.
  // zero follows out_valid, so it drops when a bubble is loaded.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      zero      <= s1_valid && (fine_val == '0);
      if (s1_valid) begin
        result <= fine_val;
      end
    end
  end

endmodule
